inst_fetch: RTL

Instruction fetch unit for the MIPS core. It owns the PC and issues word reads to a synchronous instruction RAM with 1-cycle read latency. It presents each fetched instruction, with its PC, to the `controller`/datapath decode stage. It applies the `jump`/`pcsrc` decisions that the decoder returns.

---
 rtl/mips_pkg.sv | 13 +
 rtl/pc_target_calc.sv | 17 +
 rtl/inst_fetch.sv | 109 ++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core types and constants: fetch FSM states, nop encoding, word size.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_BUBBLE = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INST   = 32'h0000_0000;
    localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational redirect target for the presented instruction: J-type region jump
// when i_jump, otherwise PC-relative branch (sign-extended word offset, wraps mod 2^32).
module pc_target_calc (
    input  logic [31:0] i_instruction,
    input  logic [31:0] i_pc_plus4,
    input  logic        i_jump,
    output logic [31:0] o_target
);

    logic [31:0] w_jump_target;
    logic [31:0] w_branch_target;

    assign w_jump_target   = {i_pc_plus4[31:28], i_instruction[25:0], 2'b00};
    assign w_branch_target = i_pc_plus4 + {{14{i_instruction[15]}}, i_instruction[15:0], 2'b00};
    assign o_target        = i_jump ? w_jump_target : w_branch_target;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, reads a 1-cycle-latency RAM, one-entry skid for stalls.
// INST_FETCH_DELAY_SLOT_EN enables the MIPS branch delay slot; otherwise redirects cost one bubble.
module inst_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        jump,
    input  logic        pcsrc,
    output logic [31:0] instruction,
    output logic        inst_valid,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc_plus4
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;

    logic [31:0] r_pc_f;
    logic [31:0] r_pc_resp;
    logic        r_resp_pending;
    logic        r_hold_valid;
    logic [31:0] r_hold_inst;
    logic [31:0] r_hold_pc;

    logic        w_redirect;
    logic        w_issue;
    logic [31:0] w_target;

    assign inst_valid    = r_resp_pending | r_hold_valid;
    assign instruction   = r_hold_valid   ? r_hold_inst :
                           r_resp_pending ? imem_rdata  : NOP_INST;
    assign inst_pc       = r_hold_valid ? r_hold_pc : r_pc_resp;
    assign inst_pc_plus4 = inst_pc + WORD_BYTES;

    // Decoder outputs only count once the presented instruction is actually accepted.
    assign w_redirect = inst_valid & ~stall & (jump | pcsrc);

    assign imem_en   = w_issue;
    assign imem_addr = r_pc_f;

    pc_target_calc u_target (
        .i_instruction (instruction),
        .i_pc_plus4    (inst_pc_plus4),
        .i_jump        (jump),
        .o_target      (w_target)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        if (r_state != ST_BOOT && !stall) begin
`ifdef INST_FETCH_DELAY_SLOT_EN
            w_issue = 1'b1;
`else
            w_issue = ~w_redirect;
`endif
        end
        case (r_state)
            ST_BOOT:   w_state_nxt = ST_RUN;
            ST_RUN: begin
`ifndef INST_FETCH_DELAY_SLOT_EN
                if (w_redirect) begin
                    w_state_nxt = ST_BUBBLE;
                end
`endif
            end
            ST_BUBBLE: w_state_nxt = ST_RUN;
            default:   w_state_nxt = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_BOOT;
            r_pc_f         <= RESET_PC;
            r_pc_resp      <= '0;
            r_resp_pending <= 1'b0;
            r_hold_valid   <= 1'b0;
            r_hold_inst    <= NOP_INST;
            r_hold_pc      <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_resp_pending <= w_issue;
            if (w_issue) begin
                r_pc_f    <= r_pc_f + WORD_BYTES;
                r_pc_resp <= r_pc_f;
            end
            // Redirect overrides the sequential increment (delay-slot request already issued).
            if (w_redirect) begin
                r_pc_f <= w_target;
            end
            if (r_resp_pending && stall && !r_hold_valid) begin
                r_hold_valid <= 1'b1;
                r_hold_inst  <= imem_rdata;
                r_hold_pc    <= r_pc_resp;
            end else if (!stall) begin
                r_hold_valid <= 1'b0;
            end
        end
    end

endmodule
